// File: rtl/chromosome_evaluator_fsm_if.sv
// Evaluator bundle: run control, config, sequence RAM, phenotype and trace signals.
// slave  : the evaluator side (chromosome_evaluator_fsm).
// master : the controller / RAM / phenotype side driving the evaluator.
interface chromosome_evaluator_fsm_if #(
  parameter int IN_W      = 8,
  parameter int OUT_W     = 8,
  parameter int SEQ_DEPTH = 128,
  parameter int SUM_W     = 32,
  parameter int LOG_AW    = 15
);
  localparam int ADDR_W = $clog2(SEQ_DEPTH);

  // run control and configuration
  logic                            iStart;
  logic                            iDoneAck;
  logic                            iMode;
  logic [ADDR_W:0]                 iSeqCount;
  logic [15:0]                     iHoldCycles;
  logic [15:0]                     iIgnoreCycles;
  logic                            iAbortEn;
  logic [SUM_W+2:0]                iAbortThresh;
  // sequence RAM
  logic [ADDR_W-1:0]               oSeqAddr;
  logic [IN_W-1:0]                 iSeqInput;
  logic [OUT_W-1:0]                iSeqExpected;
  logic [OUT_W-1:0]                iSeqValid;
  // phenotype
  logic                            oChromZero;
  logic [IN_W-1:0]                 oChromIn;
  logic [OUT_W-1:0]                iChromOut;
  // status and results
  logic                            oReady;
  logic                            oDone;
  logic                            oAborted;
  logic [OUT_W*SUM_W-1:0]          oErrorSums;
  logic [SUM_W+2:0]                oTotalError;
  logic [2:0]                      oState;
  // trace stream
  logic                            oLogWe;
  logic [LOG_AW-1:0]               oLogAddr;
  logic [IN_W+ADDR_W+2*OUT_W-1:0]  oLogData;

  modport slave (
    input  iStart, iDoneAck, iMode, iSeqCount, iHoldCycles, iIgnoreCycles,
           iAbortEn, iAbortThresh, iSeqInput, iSeqExpected, iSeqValid, iChromOut,
    output oSeqAddr, oChromZero, oChromIn, oReady, oDone, oAborted, oErrorSums,
           oTotalError, oState, oLogWe, oLogAddr, oLogData
  );

  modport master (
    output iStart, iDoneAck, iMode, iSeqCount, iHoldCycles, iIgnoreCycles,
           iAbortEn, iAbortThresh, iSeqInput, iSeqExpected, iSeqValid, iChromOut,
    input  oSeqAddr, oChromZero, oChromIn, oReady, oDone, oAborted, oErrorSums,
           oTotalError, oState, oLogWe, oLogAddr, oLogData
  );
endinterface

// File: rtl/chromosome_evaluator_fsm.sv
// Purpose: steps one phenotype through stored input/expected/valid sequences, accumulating per-bit errors.
// Latency: ZERO_CYCLES zeroing cycles, then max(iHoldCycles,1)+3 cycles per sequence, then DONE.
// Backpressure: none on the trace/RAM paths; DONE holds results until iDoneAck.
// Ports: iClock/iResetN (sync, active low) plus the slave side of chromosome_evaluator_fsm_if
//   (run control, config, sequence RAM read, phenotype drive/sample, results, trace stream).
module chromosome_evaluator_fsm #(
  parameter int IN_W        = 8,
  parameter int OUT_W       = 8,
  parameter int SEQ_DEPTH   = 128,
  parameter int SUM_W       = 32,
  parameter int ZERO_CYCLES = 2,
  parameter int LOG_AW      = 15
) (
  input logic                       iClock,
  input logic                       iResetN,
  chromosome_evaluator_fsm_if.slave bus
);
  localparam int ADDR_W = $clog2(SEQ_DEPTH);
  localparam int TOT_W  = SUM_W + 3;
  // wide enough to hold sum + a 16-bit sample count without wrapping
  localparam int SAT_W  = ((SUM_W > 16) ? SUM_W : 16) + 1;
  localparam logic [SUM_W-1:0] SUM_MAX = '1;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    ZERO  = 3'd1,
    FETCH = 3'd2,
    LOAD  = 3'd3,
    RUN   = 3'd4,
    FOLD  = 3'd5,
    DONE  = 3'd6
  } state_t;

  state_t state, stateNext;

  logic [ADDR_W-1:0]  idx;
  logic [15:0]        cnt;        // ZERO dwell counter, then RUN hold counter
  logic [IN_W-1:0]    chromIn;
  logic [OUT_W-1:0]   expReg;
  logic [OUT_W-1:0]   vldReg;
  logic [15:0]        samp    [OUT_W];
  logic [SUM_W-1:0]   sum     [OUT_W];
  logic [SUM_W-1:0]   sumNext [OUT_W];
  logic [SAT_W-1:0]   foldAdd [OUT_W];
  logic [SAT_W-1:0]   foldExt [OUT_W];
  logic [TOT_W-1:0]   total;
  logic [TOT_W-1:0]   totalNext;
  logic               aborted;
  logic [LOG_AW-1:0]  logAddr;
  logic [OUT_W*SUM_W-1:0] errorSums;

  logic [15:0]        holdEff;
  logic               holdLast;
  logic               zeroLast;
  logic               seqLast;
  logic               sampleNow;
  logic               abortHit;
  logic [OUT_W-1:0]   errBits;
  logic               ready, done, chromZero, logWe;

  assign holdEff   = (bus.iHoldCycles == 16'd0) ? 16'd1 : bus.iHoldCycles;
  assign holdLast  = (cnt == holdEff - 16'd1);
  assign zeroLast  = (cnt == 16'(ZERO_CYCLES - 1));
  assign seqLast   = ({1'b0, idx} == bus.iSeqCount - (ADDR_W + 1)'(1));
  assign sampleNow = (cnt >= bus.iIgnoreCycles);
  assign errBits   = (bus.iChromOut ^ expReg) & vldReg;

  // Fold of the current sequence into the running sums; the abort decision
  // must see the post-fold total, so it is formed combinationally here.
  always_comb begin
    totalNext = '0;
    for (int b = 0; b < OUT_W; b++) begin
      if (bus.iMode) foldAdd[b] = SAT_W'(samp[b]);
      else           foldAdd[b] = SAT_W'(samp[b] != 16'd0);
      foldExt[b] = SAT_W'(sum[b]) + foldAdd[b];
      sumNext[b] = (foldExt[b] > SAT_W'(SUM_MAX)) ? SUM_MAX : foldExt[b][SUM_W-1:0];
      totalNext  = totalNext + TOT_W'(sumNext[b]);
    end
  end

  assign abortHit = bus.iAbortEn && (totalNext > bus.iAbortThresh);

  always_ff @(posedge iClock) begin
    if (!iResetN) state <= IDLE;
    else          state <= stateNext;
  end

  always_comb begin
    stateNext = state;
    ready     = 1'b0;
    done      = 1'b0;
    chromZero = 1'b0;
    logWe     = 1'b0;
    unique case (state)
      IDLE: begin
        ready = 1'b1;
        if (bus.iStart) stateNext = ZERO;
      end
      ZERO: begin
        chromZero = 1'b1;
        if (zeroLast) stateNext = (bus.iSeqCount == '0) ? DONE : FETCH;
      end
      FETCH: stateNext = LOAD;
      LOAD:  stateNext = RUN;
      RUN: begin
        logWe = 1'b1;
        if (holdLast) stateNext = FOLD;
      end
      FOLD: stateNext = (abortHit || seqLast) ? DONE : FETCH;
      DONE: begin
        done = 1'b1;
        // iDoneAck wins; a simultaneous iStart is not carried into a new run
        if (bus.iDoneAck) stateNext = IDLE;
      end
      default: stateNext = IDLE;
    endcase
  end

  always_ff @(posedge iClock) begin
    if (!iResetN) begin
      idx     <= '0;
      cnt     <= '0;
      chromIn <= '0;
      expReg  <= '0;
      vldReg  <= '0;
      total   <= '0;
      aborted <= 1'b0;
      logAddr <= '0;
      for (int b = 0; b < OUT_W; b++) begin
        samp[b] <= '0;
        sum[b]  <= '0;
      end
    end else begin
      unique case (state)
        IDLE: begin
          if (bus.iStart) begin
            idx     <= '0;
            cnt     <= '0;
            total   <= '0;
            aborted <= 1'b0;
            logAddr <= '0;
            for (int b = 0; b < OUT_W; b++) sum[b] <= '0;
          end
        end
        ZERO: cnt <= zeroLast ? 16'd0 : cnt + 16'd1;
        LOAD: begin
          chromIn <= bus.iSeqInput;
          expReg  <= bus.iSeqExpected;
          vldReg  <= bus.iSeqValid;
          cnt     <= '0;
          for (int b = 0; b < OUT_W; b++) samp[b] <= '0;
        end
        RUN: begin
          logAddr <= logAddr + LOG_AW'(1);
          if (sampleNow) begin
            for (int b = 0; b < OUT_W; b++) samp[b] <= samp[b] + 16'(errBits[b]);
          end
          if (!holdLast) cnt <= cnt + 16'd1;
        end
        FOLD: begin
          for (int b = 0; b < OUT_W; b++) sum[b] <= sumNext[b];
          total <= totalNext;
          if (abortHit)     aborted <= 1'b1;
          else if (!seqLast) idx    <= idx + ADDR_W'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    errorSums = '0;
    for (int b = 0; b < OUT_W; b++) errorSums[b*SUM_W +: SUM_W] = sum[b];
  end

  assign bus.oSeqAddr    = idx;
  assign bus.oChromZero  = chromZero;
  assign bus.oChromIn    = chromIn;
  assign bus.oReady      = ready;
  assign bus.oDone       = done;
  assign bus.oAborted    = aborted;
  assign bus.oErrorSums  = errorSums;
  assign bus.oTotalError = total;
  assign bus.oState      = state;
  assign bus.oLogWe      = logWe;
  assign bus.oLogAddr    = logAddr;
  assign bus.oLogData    = {chromIn, idx, expReg, bus.iChromOut};
endmodule

// File: tb/tb_chromosome_evaluator_fsm.sv
module tb_chromosome_evaluator_fsm;
  localparam int OUT_W = 8;
  localparam int SEQ_DEPTH = 128;
  localparam int ZC = 2;

  logic clk = 1'b0;
  logic rstN = 1'b0;
  always #5 clk = ~clk;

  // A: default widths; B: narrow sums and trace address, run in lockstep with A
  chromosome_evaluator_fsm_if #(.IN_W(8), .OUT_W(8), .SEQ_DEPTH(128), .SUM_W(32), .LOG_AW(15)) busA ();
  chromosome_evaluator_fsm_if #(.IN_W(8), .OUT_W(8), .SEQ_DEPTH(128), .SUM_W(4),  .LOG_AW(4))  busB ();

  chromosome_evaluator_fsm #(.IN_W(8), .OUT_W(8), .SEQ_DEPTH(128), .SUM_W(32), .ZERO_CYCLES(2), .LOG_AW(15))
    dutA (.iClock(clk), .iResetN(rstN), .bus(busA));
  chromosome_evaluator_fsm #(.IN_W(8), .OUT_W(8), .SEQ_DEPTH(128), .SUM_W(4),  .ZERO_CYCLES(2), .LOG_AW(4))
    dutB (.iClock(clk), .iResetN(rstN), .bus(busB));

  logic [7:0] ramIn  [SEQ_DEPTH];
  logic [7:0] ramExp [SEQ_DEPTH];
  logic [7:0] ramVld [SEQ_DEPTH];
  logic [7:0] faultByIn [256];   // phenotype flips these output bits for a given input

  always @(posedge clk) begin
    busA.iSeqInput    <= ramIn[busA.oSeqAddr];
    busA.iSeqExpected <= ramExp[busA.oSeqAddr];
    busA.iSeqValid    <= ramVld[busA.oSeqAddr];
    busB.iSeqInput    <= ramIn[busB.oSeqAddr];
    busB.iSeqExpected <= ramExp[busB.oSeqAddr];
    busB.iSeqValid    <= ramVld[busB.oSeqAddr];
  end

  assign busA.iChromOut = ~busA.oChromIn ^ faultByIn[busA.oChromIn];
  assign busB.iChromOut = ~busB.oChromIn ^ faultByIn[busB.oChromIn];

  assign busB.iStart        = busA.iStart;
  assign busB.iDoneAck      = busA.iDoneAck;
  assign busB.iMode         = busA.iMode;
  assign busB.iSeqCount     = busA.iSeqCount;
  assign busB.iHoldCycles   = busA.iHoldCycles;
  assign busB.iIgnoreCycles = busA.iIgnoreCycles;
  assign busB.iAbortEn      = busA.iAbortEn;
  assign busB.iAbortThresh  = busA.iAbortThresh[6:0];

  int nTests = 0;
  int nFail = 0;

  task automatic chk(input string nm, input longint act, input longint exp);
    nTests++;
    if (act !== exp) begin
      nFail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  function automatic logic [7:0] phen(input logic [7:0] v);
    return ~v ^ faultByIn[v];
  endfunction

  // ---------------- behavioural model ----------------
  int mH, mRun, mIdx;
  bit mAbort;
  longint raw [OUT_W];

  task automatic computeModel();
    int samples;
    longint tot;
    logic [7:0] err;
    mH = (busA.iHoldCycles == 16'd0) ? 1 : int'(busA.iHoldCycles);
    samples = (int'(busA.iIgnoreCycles) >= mH) ? 0 : mH - int'(busA.iIgnoreCycles);
    for (int b = 0; b < OUT_W; b++) raw[b] = 0;
    mRun = 0; mIdx = 0; mAbort = 1'b0;
    for (int i = 0; i < int'(busA.iSeqCount); i++) begin
      err = (phen(ramIn[i]) ^ ramExp[i]) & ramVld[i];
      tot = 0;
      for (int b = 0; b < OUT_W; b++) begin
        if (err[b]) raw[b] += busA.iMode ? longint'(samples) : longint'(samples > 0);
        tot += raw[b];
      end
      mRun = i + 1;
      mIdx = i;
      if (busA.iAbortEn && tot > longint'(busA.iAbortThresh)) begin
        mAbort = 1'b1;
        break;
      end
    end
  endtask

  task automatic checkResults();
    longint tA, tB, sB;
    tA = 0; tB = 0;
    for (int b = 0; b < OUT_W; b++) begin
      sB = (raw[b] > 15) ? 15 : raw[b];
      chk($sformatf("sumA[%0d]", b), busA.oErrorSums[b*32 +: 32], raw[b]);
      chk($sformatf("sumB[%0d]", b), busB.oErrorSums[b*4 +: 4], sB);
      tA += raw[b];
      tB += sB;
    end
    chk("totalA", busA.oTotalError, tA);
    chk("totalB", busB.oTotalError, tB);
    chk("abortedA", busA.oAborted, mAbort);
    chk("abortedB", busB.oAborted, mAbort);
    chk("logaddrA", busA.oLogAddr, (mRun * mH) % 32768);
    chk("logaddrB", busB.oLogAddr, (mRun * mH) % 16);
    chk("idx", busA.oSeqAddr, mIdx);
    chk("doneB", busB.oDone, 1);
  endtask

  // Timeline: cycle kk after the start edge; ZERO for ZC cycles, then
  // FETCH, LOAD, H x RUN, FOLD per sequence, then DONE.
  task automatic checkCycle(input int kk);
    int st, seq, p, r, w;
    logic [30:0] ld;
    seq = 0; p = 0;
    if (kk <= ZC) st = 1;
    else begin
      r = kk - ZC - 1;
      seq = r / (mH + 3);
      p = r % (mH + 3);
      if (seq >= mRun) st = 6;
      else if (p == 0) st = 2;
      else if (p == 1) st = 3;
      else if (p <= mH + 1) st = 4;
      else st = 5;
    end
    chk("state", busA.oState, st);
    chk("ready", busA.oReady, 0);
    chk("done", busA.oDone, st == 6);
    chk("chromzero", busA.oChromZero, st == 1);
    chk("logwe", busA.oLogWe, st == 4);
    if (st == 2) chk("seqaddr", busA.oSeqAddr, seq);
    if (st == 4) begin
      w = seq * mH + p - 2;
      ld = {ramIn[seq], 7'(seq), ramExp[seq], phen(ramIn[seq])};
      chk("chromin", busA.oChromIn, ramIn[seq]);
      chk("run_logaddr", busA.oLogAddr, w % 32768);
      chk("logdata", busA.oLogData, ld);
    end
    if (st == 6) checkResults();
  endtask

  bit modelOn = 1'b0;
  int k = 0;
  always @(posedge clk) begin
    #1;
    if (!modelOn) k = 0;
    else begin
      k++;
      checkCycle(k);
    end
  end

  // ---------------- stimulus ----------------
  task automatic setCfg(input bit mode, input int cnt, input int hold, input int ign,
                        input bit aen, input int thr);
    busA.iMode = mode;
    busA.iSeqCount = 8'(cnt);
    busA.iHoldCycles = 16'(hold);
    busA.iIgnoreCycles = 16'(ign);
    busA.iAbortEn = aen;
    busA.iAbortThresh = 35'(thr);
  endtask

  task automatic runTest(input bit poke);
    computeModel();
    @(negedge clk); busA.iStart = 1'b1; modelOn = 1'b1;
    @(negedge clk); busA.iStart = 1'b0;
    if (poke) begin
      repeat (40) @(negedge clk);
      busA.iStart = 1'b1;
      @(negedge clk); busA.iStart = 1'b0;
    end
    for (int c = 0; c < 5000; c++) begin
      if (busA.oDone) break;
      @(negedge clk);
    end
    chk("done_reached", busA.oDone, 1);
    repeat (2) @(negedge clk);
  endtask

  task automatic ackDone(input bit withStart);
    @(negedge clk);
    modelOn = 1'b0;
    busA.iDoneAck = 1'b1;
    busA.iStart = withStart;
    @(posedge clk); #1;
    chk("ack_state", busA.oState, 0);
    chk("ack_ready", busA.oReady, 1);
    @(negedge clk); busA.iDoneAck = 1'b0; busA.iStart = 1'b0;
    @(posedge clk); #1;
    chk("idle_hold", busA.oState, 0);
  endtask

  initial begin
    busA.iStart = 1'b0;
    busA.iDoneAck = 1'b0;
    setCfg(0, 0, 1, 0, 0, 0);
    for (int i = 0; i < 256; i++) faultByIn[i] = 8'h00;
    for (int i = 0; i < SEQ_DEPTH; i++) begin
      ramIn[i] = 8'(i + 1);
      ramExp[i] = ~ramIn[i];
      ramVld[i] = 8'hFF;
    end
    // bit 3 wrong on seq 1 and 2; seq 2 also has bit 5 wrong but masked off
    faultByIn[ramIn[1]] = 8'h08;
    faultByIn[ramIn[2]] = 8'h28;
    ramVld[2] = 8'hDF;

    repeat (3) @(posedge clk); #1;
    chk("rst_ready", busA.oReady, 1);
    chk("rst_state", busA.oState, 0);
    chk("rst_done", busA.oDone, 0);
    chk("rst_sums", busA.oErrorSums, 0);
    chk("rst_total", busA.oTotalError, 0);
    chk("rst_aborted", busA.oAborted, 0);
    chk("rst_logaddr", busA.oLogAddr, 0);
    chk("rst_chromin", busA.oChromIn, 0);
    chk("rst_logwe", busA.oLogWe, 0);
    chk("rst_zero", busA.oChromZero, 0);
    @(negedge clk); rstN = 1'b1;

    // mode 0, with a stray iStart mid-run that must be ignored
    setCfg(0, 4, 100, 5, 0, 0);
    runTest(1'b1);
    chk("m0_sum3", busA.oErrorSums[3*32 +: 32], 2);
    chk("m0_sum5", busA.oErrorSums[5*32 +: 32], 0);
    chk("m0_total", busA.oTotalError, 2);
    chk("m0_aborted", busA.oAborted, 0);
    ackDone(1'b0);

    // mode 1: 95 sampled cycles per faulty sequence
    setCfg(1, 4, 100, 5, 0, 0);
    runTest(1'b0);
    chk("m1_sum3", busA.oErrorSums[3*32 +: 32], 190);
    chk("m1_sum3_sat", busB.oErrorSums[3*4 +: 4], 15);
    ackDone(1'b0);

    // total equal to threshold does not abort
    setCfg(0, 4, 3, 0, 1, 2);
    runTest(1'b0);
    chk("thr_eq_aborted", busA.oAborted, 0);
    chk("thr_eq_total", busA.oTotalError, 2);
    ackDone(1'b0);

    // threshold 1: abort after seq 2
    setCfg(0, 4, 3, 0, 1, 1);
    runTest(1'b0);
    chk("thr1_aborted", busA.oAborted, 1);
    chk("thr1_idx", busA.oSeqAddr, 2);
    ackDone(1'b0);

    // abort on the first sequence; ack together with start returns to IDLE only
    faultByIn[ramIn[0]] = 8'h01;
    setCfg(0, 4, 3, 0, 1, 0);
    runTest(1'b0);
    chk("abort_aborted", busA.oAborted, 1);
    chk("abort_idx", busA.oSeqAddr, 0);
    chk("abort_total", busA.oTotalError, 1);
    ackDone(1'b1);

    // saturation and trace wrap on the narrow instance
    setCfg(1, 1, 20, 0, 0, 0);
    runTest(1'b0);
    chk("sat_sumA0", busA.oErrorSums[0 +: 32], 20);
    chk("sat_sumB0", busB.oErrorSums[0 +: 4], 15);
    chk("wrap_logaddrB", busB.oLogAddr, 4);
    ackDone(1'b0);

    // no sequences
    setCfg(1, 0, 5, 0, 0, 0);
    runTest(1'b0);
    chk("cnt0_total", busA.oTotalError, 0);
    ackDone(1'b0);

    // ignore window covers the whole hold
    setCfg(1, 4, 10, 10, 0, 0);
    runTest(1'b0);
    chk("ign_eq_total", busA.oTotalError, 0);
    ackDone(1'b0);
    setCfg(1, 4, 10, 11, 0, 0);
    runTest(1'b0);
    chk("ign_gt_total", busA.oTotalError, 0);
    ackDone(1'b0);

    // hold 0 behaves as hold 1
    setCfg(1, 3, 0, 0, 0, 0);
    runTest(1'b0);
    chk("h0_logaddr", busA.oLogAddr, 3);
    chk("h0_total", busA.oTotalError, 3);
    ackDone(1'b0);

    // reset in the middle of seq 2's RUN
    setCfg(1, 4, 20, 0, 0, 0);
    computeModel();
    @(negedge clk); busA.iStart = 1'b1; modelOn = 1'b1;
    @(negedge clk); busA.iStart = 1'b0;
    for (int c = 0; c < 1000; c++) begin
      if (busA.oState == 3'd4 && busA.oLogAddr >= 15'd45) break;
      @(negedge clk);
    end
    chk("mid_run_state", busA.oState, 4);
    chk("mid_run_sum3", busA.oErrorSums[3*32 +: 32], 20);
    modelOn = 1'b0;
    rstN = 1'b0;
    @(posedge clk); #1;
    chk("mrst_state", busA.oState, 0);
    chk("mrst_ready", busA.oReady, 1);
    chk("mrst_sums", busA.oErrorSums, 0);
    chk("mrst_total", busA.oTotalError, 0);
    chk("mrst_logaddr", busA.oLogAddr, 0);
    chk("mrst_aborted", busA.oAborted, 0);
    chk("mrst_readyB", busB.oReady, 1);
    @(negedge clk); rstN = 1'b1;
    repeat (2) @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", nTests, nFail);
    $finish;
  end
endmodule
